// File: rtl/pll_lock_supervisor.sv
// Multi-channel PLL supervisor: drives PLL resets, waits for lock with timeout/retry,
// qualifies lock over a stability window and counts losses. Macro PLL_SUP_AUTO_RETRY_EN selects re-reset on loss.
module pll_lock_supervisor #(
  parameter int CH_NUM     = 2,
  parameter int RST_CYCLES = 16,
  parameter int LOCK_WAIT  = 100000,
  parameter int STABLE_CNT = 1024,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CH_NUM-1:0]         pll_lock,
  input  logic                      clr,
  output logic [CH_NUM-1:0]         pll_rst,
  output logic [CH_NUM-1:0]         lock_ok,
  output logic                      all_locked,
  output logic [CH_NUM-1:0]         fail,
  output logic [CH_NUM*CNT_W-1:0]   loss_cnt
);

  localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WAIT_W = (LOCK_WAIT  > 1) ? $clog2(LOCK_WAIT)  : 1;
  localparam int STAB_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int RTY_W  = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_WAIT - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  logic [CH_NUM-1:0] r_sync1;
  logic [CH_NUM-1:0] r_lk_s;
  logic [CH_NUM-1:0] w_lock_ok;
  logic              r_all_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_lk_s  <= '0;
    end else begin
      r_sync1 <= pll_lock;
      r_lk_s  <= r_sync1;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_t            r_state,    w_state_nxt;
    logic [RST_W-1:0]  r_rst_cnt,  w_rst_cnt_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [STAB_W-1:0] r_stab_cnt, w_stab_cnt_nxt;
    logic [RTY_W-1:0]  r_retry,    w_retry_nxt;
    logic [CNT_W-1:0]  r_loss,     w_loss_nxt;
    logic              w_loss_evt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= S_RESET;
        r_rst_cnt  <= '0;
        r_wait_cnt <= '0;
        r_stab_cnt <= '0;
        r_retry    <= '0;
        r_loss     <= '0;
      end else begin
        r_state    <= w_state_nxt;
        r_rst_cnt  <= w_rst_cnt_nxt;
        r_wait_cnt <= w_wait_cnt_nxt;
        r_stab_cnt <= w_stab_cnt_nxt;
        r_retry    <= w_retry_nxt;
        r_loss     <= w_loss_nxt;
      end
    end

    always_comb begin
      w_state_nxt    = r_state;
      w_rst_cnt_nxt  = r_rst_cnt;
      w_wait_cnt_nxt = r_wait_cnt;
      w_stab_cnt_nxt = r_stab_cnt;
      w_retry_nxt    = r_retry;
      w_loss_nxt     = r_loss;
      w_loss_evt     = 1'b0;

      case (r_state)
        S_RESET: begin
          if (r_rst_cnt == RST_LAST) begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = '0;
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_lk_s[g]) begin
            w_state_nxt    = S_STABLE;
            w_stab_cnt_nxt = '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_retry_nxt = r_retry + 1'b1;
            if (w_retry_nxt == RTY_MAX) begin
              w_state_nxt = S_FAIL;
            end else begin
              w_state_nxt   = S_RESET;
              w_rst_cnt_nxt = '0;
            end
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!r_lk_s[g]) begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = '0;
          end else if (r_stab_cnt == STAB_LAST) begin
            w_state_nxt = S_LOCKED;
            w_retry_nxt = '0;
          end else begin
            w_stab_cnt_nxt = r_stab_cnt + 1'b1;
          end
        end
        S_LOCKED: begin
          if (!r_lk_s[g]) begin
            w_loss_evt = 1'b1;
`ifdef PLL_SUP_AUTO_RETRY_EN
            w_state_nxt   = S_RESET;
            w_rst_cnt_nxt = '0;
            w_retry_nxt   = '0;
`else
            w_state_nxt = S_FAIL;
`endif
          end
        end
        S_FAIL: begin
          w_state_nxt = S_FAIL;
        end
        default: begin
          w_state_nxt   = S_RESET;
          w_rst_cnt_nxt = '0;
        end
      endcase

      // clr dominates: any move into FAIL this cycle is redirected to a fresh reset pulse
      if (clr) begin
        w_retry_nxt = '0;
        if (w_state_nxt == S_FAIL) begin
          w_state_nxt   = S_RESET;
          w_rst_cnt_nxt = '0;
        end
      end

      if (clr) begin
        w_loss_nxt = '0;
      end else if (w_loss_evt && (r_loss != {CNT_W{1'b1}})) begin
        w_loss_nxt = r_loss + 1'b1;
      end
    end

    assign pll_rst[g]                   = (r_state == S_RESET) || (r_state == S_FAIL);
    assign w_lock_ok[g]                 = (r_state == S_LOCKED);
    assign fail[g]                      = (r_state == S_FAIL);
    assign loss_cnt[g*CNT_W +: CNT_W]   = r_loss;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all_locked <= 1'b0;
    end else begin
      r_all_locked <= &w_lock_ok;
    end
  end

  assign lock_ok    = w_lock_ok;
  assign all_locked = r_all_locked;

endmodule
